noc_packetizer: RTL and testbench

- Network-interface injection stage sitting directly upstream of the router LOCAL input port.
- Accepts a message descriptor (destination, head payload, body length) plus a stream of body words and emits a packet as a sequence of flit_novc_t flits: HEADTAIL, or HEAD / BODY... / TAIL.
- Flow control toward the router is credit-based; the block never sends a flit without a credit.

---
 rtl/noc_packetizer.sv | 154 +++++++++++++++
 tb/tb_noc_packetizer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_packetizer.sv
// Network-interface injection stage: turns a message descriptor plus body words into
// HEADTAIL or HEAD/BODY.../TAIL flits toward the router LOCAL port under credit flow control.
module noc_packetizer #(
    parameter int BUFFER_DEPTH      = 4,
    parameter int MAX_BODY_FLITS    = 15,
    parameter int DEST_ADDR_SIZE_X  = 4,
    parameter int DEST_ADDR_SIZE_Y  = 4,
    parameter int HEAD_PAYLOAD_SIZE = 16,
    localparam int FLIT_DATA_SIZE   = DEST_ADDR_SIZE_X + DEST_ADDR_SIZE_Y + HEAD_PAYLOAD_SIZE,
    localparam int LEN_W            = $clog2(MAX_BODY_FLITS + 1),
    localparam int CRED_W           = $clog2(BUFFER_DEPTH + 1),
    localparam int FLIT_W           = FLIT_DATA_SIZE + 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         msg_valid_i,
    output logic                         msg_ready_o,
    input  logic [DEST_ADDR_SIZE_X-1:0]  msg_x_dest_i,
    input  logic [DEST_ADDR_SIZE_Y-1:0]  msg_y_dest_i,
    input  logic [HEAD_PAYLOAD_SIZE-1:0] msg_head_pl_i,
    input  logic [LEN_W-1:0]             msg_body_len_i,
    input  logic                         body_valid_i,
    output logic                         body_ready_o,
    input  logic [FLIT_DATA_SIZE-1:0]    body_data_i,
    output logic [FLIT_W-1:0]            flit_o,
    output logic                         flit_valid_o,
    input  logic                         credit_i,
    output logic                         idle_o
);

    // Label encoding occupies the two MSBs of the flit: HEAD=0, BODY=1, TAIL=2, HEADTAIL=3.
    typedef enum logic [1:0] {HEAD = 2'd0, BODY = 2'd1, TAIL = 2'd2, HEADTAIL = 2'd3} flit_label_t;

    typedef struct packed {
        logic [DEST_ADDR_SIZE_X-1:0]  x_dest;
        logic [DEST_ADDR_SIZE_Y-1:0]  y_dest;
        logic [HEAD_PAYLOAD_SIZE-1:0] head_pl;
    } head_data_t;

    typedef struct packed {
        flit_label_t               flit_label;
        logic [FLIT_DATA_SIZE-1:0] data;
    } flit_novc_t;

    typedef enum logic [1:0] {IDLE, SEND_HEAD, SEND_BODY} state_t;

    localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(BUFFER_DEPTH);
    localparam logic [LEN_W-1:0]  LEN_MAX  = LEN_W'(MAX_BODY_FLITS);

    state_t            state, state_next;
    logic [CRED_W-1:0] credits, credits_next;
    logic [LEN_W-1:0]  remaining, remaining_next;
    head_data_t        head_q;
    flit_novc_t        flit_q, flit_next;
    logic              flit_valid_q;
    logic              has_credit;
    logic              send;

    // Only the credit count registered at the start of the cycle may enable a send.
    assign has_credit = (credits != '0);

    always_comb begin
        state_next     = state;
        remaining_next = remaining;
        flit_next      = flit_q;
        send           = 1'b0;
        msg_ready_o    = 1'b0;
        body_ready_o   = 1'b0;
        case (state)
            IDLE: begin
                msg_ready_o = 1'b1;
                if (msg_valid_i) begin
                    remaining_next = (msg_body_len_i > LEN_MAX) ? LEN_MAX : msg_body_len_i;
                    state_next     = SEND_HEAD;
                end
            end
            SEND_HEAD: begin
                if (has_credit) begin
                    send           = 1'b1;
                    flit_next.data = head_q;
                    if (remaining == '0) begin
                        flit_next.flit_label = HEADTAIL;
                        state_next           = IDLE;
                    end else begin
                        flit_next.flit_label = HEAD;
                        state_next           = SEND_BODY;
                    end
                end
            end
            SEND_BODY: begin
                body_ready_o = has_credit;
                if (body_valid_i && has_credit) begin
                    send           = 1'b1;
                    flit_next.data = body_data_i;
                    remaining_next = remaining - 1'b1;
                    if (remaining == LEN_W'(1)) begin
                        flit_next.flit_label = TAIL;
                        state_next           = IDLE;
                    end else begin
                        flit_next.flit_label = BODY;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A returned credit in the same cycle as a send cancels out; excess returns saturate.
    always_comb begin
        credits_next = credits;
        case ({send, credit_i})
            2'b10:   credits_next = credits - 1'b1;
            2'b01:   credits_next = (credits == CRED_MAX) ? credits : credits + 1'b1;
            default: credits_next = credits;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            credits      <= CRED_MAX;
            remaining    <= '0;
            flit_q       <= '0;
            flit_valid_q <= 1'b0;
        end else begin
            state        <= state_next;
            credits      <= credits_next;
            remaining    <= remaining_next;
            flit_q       <= flit_next;
            flit_valid_q <= send;
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && msg_valid_i) begin
            head_q <= '{x_dest: msg_x_dest_i, y_dest: msg_y_dest_i, head_pl: msg_head_pl_i};
        end
    end

    assign flit_o       = flit_q;
    assign flit_valid_o = flit_valid_q;
    assign idle_o       = (state == IDLE) && (credits == CRED_MAX);

`ifndef SYNTHESIS
    // A credit while every router slot is already free means the router returned one it never had.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(credit_i && credits == CRED_MAX))
                else $error("noc_packetizer: credit_i with credits already at BUFFER_DEPTH");
        end
    end
`endif

endmodule

// File: tb/tb_noc_packetizer.sv
// Scoreboard bench for noc_packetizer: expected flits are queued when a message is issued
// and compared as flit_valid_o pulses arrive.
module tb_noc_packetizer;

    localparam int BUFFER_DEPTH = 4;
    localparam int XW = 4;
    localparam int YW = 4;
    localparam int PW = 16;
    localparam int DW = XW + YW + PW;
    localparam int LW = 4;
    localparam int FW = DW + 2;

    localparam logic [1:0] L_HEAD     = 2'd0;
    localparam logic [1:0] L_BODY     = 2'd1;
    localparam logic [1:0] L_TAIL     = 2'd2;
    localparam logic [1:0] L_HEADTAIL = 2'd3;

    logic          clk;
    logic          rst;
    logic          msg_valid_i;
    logic          msg_ready_o;
    logic [XW-1:0] msg_x_dest_i;
    logic [YW-1:0] msg_y_dest_i;
    logic [PW-1:0] msg_head_pl_i;
    logic [LW-1:0] msg_body_len_i;
    logic          body_valid_i;
    logic          body_ready_o;
    logic [DW-1:0] body_data_i;
    logic [FW-1:0] flit_o;
    logic          flit_valid_o;
    logic          credit_i;
    logic          idle_o;

    int checks = 0;
    int errors = 0;
    int sent_cnt = 0;
    int ret_cnt = 0;
    int acc_cyc = 0;
    bit body_gap_en = 1'b0;
    logic [FW-1:0] exp_q[$];
    logic [DW-1:0] body_q[$];
    int flit_cyc[$];
    logic [FW-1:0] mon_exp;

    noc_packetizer dut (
        .clk            (clk),
        .rst            (rst),
        .msg_valid_i    (msg_valid_i),
        .msg_ready_o    (msg_ready_o),
        .msg_x_dest_i   (msg_x_dest_i),
        .msg_y_dest_i   (msg_y_dest_i),
        .msg_head_pl_i  (msg_head_pl_i),
        .msg_body_len_i (msg_body_len_i),
        .body_valid_i   (body_valid_i),
        .body_ready_o   (body_ready_o),
        .body_data_i    (body_data_i),
        .flit_o         (flit_o),
        .flit_valid_o   (flit_valid_o),
        .credit_i       (credit_i),
        .idle_o         (idle_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Every observed flit must match the scoreboard head and never exceed the router's free slots.
    always @(negedge clk) begin
        if (!rst && flit_valid_o) begin
            sent_cnt++;
            flit_cyc.push_back(int'($time / 10));
            checkOutput("credit_bound", 32'(sent_cnt - ret_cnt <= BUFFER_DEPTH), 32'd1);
            checkOutput("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                mon_exp = exp_q.pop_front();
                checkOutput("flit", 32'(flit_o), 32'(mon_exp));
            end
        end
    end

    // Body words are offered from negedge to negedge; ready is register-derived so the handshake is known here.
    always @(negedge clk) begin
        if (body_q.size() != 0 && !(body_gap_en && (($time / 10) % 2 == 1))) begin
            body_valid_i = 1'b1;
            body_data_i  = body_q[0];
            if (body_ready_o) void'(body_q.pop_front());
        end else begin
            body_valid_i = 1'b0;
        end
    end

    task automatic applyStimulus(input logic [XW-1:0] x, input logic [YW-1:0] y, input logic [PW-1:0] pl,
                                 input int len, input logic [DW-1:0] base, input logic [DW-1:0] step,
                                 input int feed, input bit hold);
        int n = 0;
        logic [DW-1:0] w;
        exp_q.push_back({(len == 0) ? L_HEADTAIL : L_HEAD, x, y, pl});
        for (int i = 0; i < len; i++) begin
            w = base + DW'(i) * step;
            exp_q.push_back({(i == len - 1) ? L_TAIL : L_BODY, w});
            if (i < feed) body_q.push_back(w);
        end
        msg_valid_i    = 1'b1;
        msg_x_dest_i   = x;
        msg_y_dest_i   = y;
        msg_head_pl_i  = pl;
        msg_body_len_i = LW'(len);
        while (!msg_ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("msg_accept", 32'(msg_ready_o), 32'd1);
        acc_cyc = int'($time / 10);
        @(negedge clk);
        if (!hold) msg_valid_i = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || body_q.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
    endtask

    task automatic return_credits(input int n);
        credit_i = 1'b1;
        repeat (n) begin
            @(negedge clk);
            ret_cnt++;
        end
        credit_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int s0;
        int n;
        rst = 1'b1; msg_valid_i = 1'b0; msg_x_dest_i = '0; msg_y_dest_i = '0;
        msg_head_pl_i = '0; msg_body_len_i = '0; body_valid_i = 1'b0; body_data_i = '0; credit_i = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_flit_valid", 32'(flit_valid_o), 32'd0);
        checkOutput("rst_flit", 32'(flit_o), 32'd0);
        checkOutput("rst_msg_ready", 32'(msg_ready_o), 32'd1);
        checkOutput("rst_body_ready", 32'(body_ready_o), 32'd0);
        checkOutput("rst_idle", 32'(idle_o), 32'd1);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] single HEADTAIL");
        s0 = flit_cyc.size();
        applyStimulus(4'd3, 4'd2, 16'hABCD, 0, '0, '0, 0, 1'b0);
        wait_drain();
        checkOutput("ht_count", 32'(flit_cyc.size() - s0), 32'd1);
        checkOutput("ht_latency", 32'(flit_cyc[s0] - acc_cyc), 32'd2);
        checkOutput("ht_idle_low", 32'(idle_o), 32'd0);
        return_credits(1);
        checkOutput("ht_idle_back", 32'(idle_o), 32'd1);

        $display("[TB] multi-flit packet");
        s0 = flit_cyc.size();
        applyStimulus(4'd1, 4'd1, 16'h1234, 3, 24'h11, 24'h11, 3, 1'b0);
        wait_drain();
        checkOutput("mf_count", 32'(flit_cyc.size() - s0), 32'd4);
        checkOutput("mf_span", 32'(flit_cyc[s0 + 3] - flit_cyc[s0]), 32'd3);
        checkOutput("mf_idle_low", 32'(idle_o), 32'd0);
        return_credits(4);
        checkOutput("mf_idle_back", 32'(idle_o), 32'd1);

        $display("[TB] credit starvation");
        s0 = flit_cyc.size();
        applyStimulus(4'd0, 4'd3, 16'h5555, 5, 24'h51, 24'h1, 5, 1'b0);
        repeat (10) @(negedge clk);
        checkOutput("st_stall_count", 32'(flit_cyc.size() - s0), 32'd4);
        checkOutput("st_body_ready", 32'(body_ready_o), 32'd0);
        checkOutput("st_words_left", 32'(body_q.size()), 32'd2);
        return_credits(1);
        repeat (4) @(negedge clk);
        checkOutput("st_one_more", 32'(flit_cyc.size() - s0), 32'd5);
        return_credits(1);
        wait_drain();
        checkOutput("st_count", 32'(flit_cyc.size() - s0), 32'd6);
        return_credits(4);
        checkOutput("st_idle_back", 32'(idle_o), 32'd1);

        $display("[TB] simultaneous credit and send");
        s0 = flit_cyc.size();
        applyStimulus(4'd2, 4'd2, 16'h4444, 5, 24'h41, 24'h1, 5, 1'b0);
        repeat (10) @(negedge clk);
        checkOutput("sc_stall_count", 32'(flit_cyc.size() - s0), 32'd4);
        return_credits(2);
        wait_drain();
        checkOutput("sc_count", 32'(flit_cyc.size() - s0), 32'd6);
        checkOutput("sc_back_to_back", 32'(flit_cyc[s0 + 5] - flit_cyc[s0 + 4]), 32'd1);
        checkOutput("sc_credits_zero", 32'(body_ready_o | idle_o), 32'd0);
        return_credits(4);

        $display("[TB] reset mid-packet");
        s0 = flit_cyc.size();
        applyStimulus(4'd5, 4'd6, 16'h6666, 4, 24'h61, 24'h1, 1, 1'b0);
        n = 0;
        while (flit_cyc.size() - s0 < 2 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("rm_partial", 32'(flit_cyc.size() - s0), 32'd2);
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        body_q.delete();
        @(negedge clk);
        rst = 1'b0;
        sent_cnt = 0;
        ret_cnt = 0;
        checkOutput("rm_flit_valid", 32'(flit_valid_o), 32'd0);
        checkOutput("rm_msg_ready", 32'(msg_ready_o), 32'd1);
        checkOutput("rm_idle", 32'(idle_o), 32'd1);
        s0 = flit_cyc.size();
        applyStimulus(4'd7, 4'd1, 16'hBEEF, 0, '0, '0, 0, 1'b0);
        wait_drain();
        checkOutput("rm_clean_count", 32'(flit_cyc.size() - s0), 32'd1);
        return_credits(1);

        $display("[TB] back-to-back messages");
        s0 = flit_cyc.size();
        applyStimulus(4'd1, 4'd2, 16'hAAAA, 1, 24'h71, 24'h0, 1, 1'b1);
        applyStimulus(4'd2, 4'd1, 16'hBBBB, 1, 24'h72, 24'h0, 1, 1'b0);
        wait_drain();
        checkOutput("bb_count", 32'(flit_cyc.size() - s0), 32'd4);
        checkOutput("bb_gap0", 32'(flit_cyc[s0 + 1] - flit_cyc[s0]), 32'd1);
        checkOutput("bb_gap1", 32'(flit_cyc[s0 + 2] - flit_cyc[s0 + 1]), 32'd2);
        checkOutput("bb_gap2", 32'(flit_cyc[s0 + 3] - flit_cyc[s0 + 2]), 32'd1);
        return_credits(4);

        $display("[TB] body gaps");
        s0 = flit_cyc.size();
        body_gap_en = 1'b1;
        applyStimulus(4'd3, 4'd3, 16'hCCCC, 3, 24'hC1, 24'h1, 3, 1'b0);
        wait_drain();
        body_gap_en = 1'b0;
        checkOutput("gap_count", 32'(flit_cyc.size() - s0), 32'd4);
        checkOutput("gap_span_gt3", 32'(flit_cyc[s0 + 3] - flit_cyc[s0] > 3), 32'd1);
        return_credits(4);
        checkOutput("final_idle", 32'(idle_o), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
